// File: rtl/gray_conv_arbiter.sv
// gray_conv_arbiter: round-robin shared binary-to-Gray converter with sweep mode
// and a single-entry backpressured output register.
module gray_conv_arbiter #(
   parameter int WIDTH = 4
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             req0_valid_in,
   input  logic [WIDTH-1:0] req0_bin_in,
   output logic             req0_ready_out,
   input  logic             req1_valid_in,
   input  logic [WIDTH-1:0] req1_bin_in,
   output logic             req1_ready_out,
   input  logic             sweep_start_in,
   output logic             gray_valid_out,
   output logic [WIDTH-1:0] gray_out,
   output logic [1:0]       gray_src_out,
   input  logic             gray_ready_in,
   output logic             sweep_busy_out,
   output logic             sweep_done_out
);
   typedef enum logic {ARB, SWEEP} state_t;
   state_t state, state_nxt;
   logic [WIDTH-1:0] cnt;
   logic last_served, free, gnt0, gnt1, sweep_load, sweep_last;

   function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // last_served=1 means req1 went last, so req0 wins the next tie
   always_comb begin
      free = !gray_valid_out || gray_ready_in;
      gnt0 = req0_valid_in && (!req1_valid_in || last_served);
      gnt1 = req1_valid_in && (!req0_valid_in || !last_served);
      req0_ready_out = !rst_in && state == ARB && free && gnt0;
      req1_ready_out = !rst_in && state == ARB && free && gnt1;
      sweep_load = state == SWEEP && free;
      sweep_last = sweep_load && cnt == '1;
      state_nxt = state == ARB ? (sweep_start_in ? SWEEP : ARB) : (sweep_last ? ARB : SWEEP);
   end

   assign sweep_busy_out = state == SWEEP;

   always_ff @(posedge clk_in or posedge rst_in)
      if (rst_in) state <= ARB;
      else state <= state_nxt;

   always_ff @(posedge clk_in or posedge rst_in)
      if (rst_in) begin
         cnt <= '0;
         last_served <= 1'b1;
         gray_valid_out <= 1'b0;
         gray_out <= '0;
         gray_src_out <= 2'd0;
         sweep_done_out <= 1'b0;
      end else begin
         sweep_done_out <= sweep_last;
         if (state == ARB && sweep_start_in) cnt <= '0;
         else if (sweep_load) cnt <= cnt + 1'b1;
         if (req0_ready_out && req0_valid_in) begin
            gray_valid_out <= 1'b1;
            gray_out <= to_gray(req0_bin_in);
            gray_src_out <= 2'd0;
            last_served <= 1'b0;
         end else if (req1_ready_out && req1_valid_in) begin
            gray_valid_out <= 1'b1;
            gray_out <= to_gray(req1_bin_in);
            gray_src_out <= 2'd1;
            last_served <= 1'b1;
         end else if (sweep_load) begin
            gray_valid_out <= 1'b1;
            gray_out <= to_gray(cnt);
            gray_src_out <= 2'd2;
         end else if (free) gray_valid_out <= 1'b0;
      end
endmodule

// File: tb/tb_gray_conv_arbiter.sv
// tb_gray_conv_arbiter: directed stimulus with a scoreboard of expected
// {src, gray} results consumed by a negedge output monitor.
module tb_gray_conv_arbiter;
   logic clk_in = 1'b0;
   logic rst_in, req0_valid_in, req1_valid_in, sweep_start_in, gray_ready_in;
   logic [3:0] req0_bin_in, req1_bin_in;
   logic req0_ready_out, req1_ready_out, gray_valid_out, sweep_busy_out, sweep_done_out;
   logic [3:0] gray_out;
   logic [1:0] gray_src_out;
   logic [5:0] q[$];
   logic [5:0] exp_item;
   int pass_cnt = 0;
   int total_cnt = 0;
   int done_cnt = 0;

   gray_conv_arbiter #(.WIDTH(4)) dut (
      .clk_in(clk_in), .rst_in(rst_in),
      .req0_valid_in(req0_valid_in), .req0_bin_in(req0_bin_in), .req0_ready_out(req0_ready_out),
      .req1_valid_in(req1_valid_in), .req1_bin_in(req1_bin_in), .req1_ready_out(req1_ready_out),
      .sweep_start_in(sweep_start_in), .gray_valid_out(gray_valid_out), .gray_out(gray_out),
      .gray_src_out(gray_src_out), .gray_ready_in(gray_ready_in),
      .sweep_busy_out(sweep_busy_out), .sweep_done_out(sweep_done_out)
   );

   always #5 clk_in = ~clk_in;

   function automatic logic [3:0] to_gray(input logic [3:0] b);
      logic [3:0] g;
      g[3] = b[3];
      for (int i = 0; i < 3; i++) g[i] = b[i+1] ^ b[i];
      return g;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic cyc(input logic e0, input logic e1, input logic eb);
      @(negedge clk_in);
      chk("req0_ready", req0_ready_out, e0);
      chk("req1_ready", req1_ready_out, e1);
      chk("sweep_busy", sweep_busy_out, eb);
      if (e0 && req0_valid_in) q.push_back({2'd0, to_gray(req0_bin_in)});
      if (e1 && req1_valid_in) q.push_back({2'd1, to_gray(req1_bin_in)});
      @(posedge clk_in);
      #1;
   endtask

   task automatic push_sweep();
      logic [3:0] b;
      for (int k = 0; k < 16; k++) begin
         b = 4'(k);
         q.push_back({2'd2, to_gray(b)});
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_valid"}, gray_valid_out, 1'b0);
      chk({tag, "_gray"}, gray_out, 4'd0);
      chk({tag, "_src"}, gray_src_out, 2'd0);
      chk({tag, "_busy"}, sweep_busy_out, 1'b0);
      chk({tag, "_done"}, sweep_done_out, 1'b0);
      chk({tag, "_ready0"}, req0_ready_out, 1'b0);
      chk({tag, "_ready1"}, req1_ready_out, 1'b0);
   endtask

   always @(negedge clk_in) begin
      if (sweep_done_out) done_cnt++;
      if (gray_valid_out && gray_ready_in) begin
         if (q.size() == 0) chk("queue_underflow", q.size(), 1);
         else begin
            exp_item = q.pop_front();
            chk("gray_out", gray_out, exp_item[3:0]);
            chk("gray_src", gray_src_out, exp_item[5:4]);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_in = 1'b1;
      req0_valid_in = 1'b1;
      req0_bin_in = 4'b0101;
      req1_valid_in = 1'b0;
      req1_bin_in = 4'b0000;
      sweep_start_in = 1'b0;
      gray_ready_in = 1'b1;
      repeat (2) @(posedge clk_in);
      #1;
      chk_all_zero("reset");
      rst_in = 1'b0;
      cyc(1, 0, 0);
      req0_valid_in = 1'b0;
      cyc(0, 0, 0);
      req1_valid_in = 1'b1;
      req1_bin_in = 4'b1111;
      cyc(0, 1, 0);
      req1_valid_in = 1'b0;
      req0_valid_in = 1'b1;
      req0_bin_in = 4'b0011;
      gray_ready_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0);
         chk("hold_valid", gray_valid_out, 1'b1);
         chk("hold_gray", gray_out, 4'b1000);
         chk("hold_src", gray_src_out, 2'd1);
      end
      gray_ready_in = 1'b1;
      req1_valid_in = 1'b1;
      req1_bin_in = 4'b1000;
      cyc(1, 0, 0);
      cyc(0, 1, 0);
      cyc(1, 0, 0);
      cyc(0, 1, 0);
      req0_valid_in = 1'b0;
      req1_valid_in = 1'b0;
      cyc(0, 0, 0);
      sweep_start_in = 1'b1;
      push_sweep();
      cyc(0, 0, 0);
      sweep_start_in = 1'b0;
      req1_valid_in = 1'b1;
      req1_bin_in = 4'b0001;
      for (int i = 0; i < 16; i++) cyc(0, 0, 1);
      cyc(0, 1, 0);
      req1_valid_in = 1'b0;
      cyc(0, 0, 0);
      chk("done_pulses_sweep1", done_cnt, 1);
      sweep_start_in = 1'b1;
      push_sweep();
      cyc(0, 0, 0);
      sweep_start_in = 1'b0;
      for (int i = 0; i < 6; i++) cyc(0, 0, 1);
      gray_ready_in = 1'b0;
      chk("stall_gray", gray_out, 4'b0111);
      cyc(0, 0, 1);
      cyc(0, 0, 1);
      chk("stall_hold_gray", gray_out, 4'b0111);
      gray_ready_in = 1'b1;
      for (int i = 0; i < 4; i++) cyc(0, 0, 1);
      chk("abort_code9", gray_out, 4'b1101);
      #1;
      rst_in = 1'b1;
      #1;
      chk_all_zero("async_reset");
      q.delete();
      @(posedge clk_in);
      #1;
      rst_in = 1'b0;
      for (int i = 0; i < 20; i++) cyc(0, 0, 0);
      chk("done_pulses_aborted", done_cnt, 1);
      req0_valid_in = 1'b1;
      req0_bin_in = 4'b0110;
      sweep_start_in = 1'b1;
      cyc(1, 0, 0);
      push_sweep();
      req0_valid_in = 1'b0;
      sweep_start_in = 1'b0;
      for (int i = 0; i < 16; i++) cyc(0, 0, 1);
      cyc(0, 0, 0);
      cyc(0, 0, 0);
      chk("done_pulses_final", done_cnt, 2);
      chk("queue_drained", q.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/gray_conv_arbiter.md
# gray_conv_arbiter

Sequential front end for the 4-bit binary-to-Gray conversion datapath. It shares one conversion resource between two requesters using round-robin arbitration and valid/ready handshakes. It also provides a self-test sweep mode that emits the Gray code of every binary value 0..2^WIDTH-1 in order. The block sits between requesting logic and any Gray-code consumer, and registers each result in a single-entry output stage with backpressure.

## Interface
- WIDTH, 4, data width of binary input and Gray output (≥2)
- clk_in  input  1  clock; all state updates on rising edge
- rst_in  input  1  asynchronous, active-high reset
- req0_valid_in  input  1  requester 0 has a binary value
- req0_bin_in  input  WIDTH  requester 0 binary value
- req0_ready_out  output  1  requester 0 transfer accepted this cycle when valid & ready
- req1_valid_in  input  1  requester 1 has a binary value
- req1_bin_in  input  WIDTH  requester 1 binary value
- req1_ready_out  output  1  requester 1 accept
- sweep_start_in  input  1  single-cycle pulse; starts exhaustive sweep
- gray_valid_out  output  1  output register holds a result
- gray_out  output  WIDTH  Gray code of the accepted binary value
- gray_src_out  output  2  source of the result: 0 = req0, 1 = req1, 2 = sweep
- gray_ready_in  input  1  consumer takes the result when valid & ready
- sweep_busy_out  output  1  sweep in progress
- sweep_done_out  output  1  one-cycle pulse after the last sweep code is loaded

## Operation
- **Conversion:** gray[WIDTH-1] = bin[WIDTH-1]; gray[i] = bin[i+1] ^ bin[i] for i < WIDTH-1. Bit WIDTH-1 is the MSB.
- **Output stage:** the register is free when !gray_valid_out || gray_ready_in.
  - A load sets gray_valid_out=1 and writes gray_out and gray_src_out.
  - If the register is free and nothing loads, gray_valid_out clears.
  - While the register is held, gray_out and gray_src_out are stable.
- **FSM:**
  - ARB (reset state) → SWEEP on sweep_start_in=1.
  - SWEEP → ARB on the edge that loads code 2^WIDTH-1.
  - sweep_start_in is ignored in SWEEP.
- **ARB arbitration:**
  - Grant goes to the only valid requester. If both are valid, grant goes to the requester not served last.
  - last_served register: reset value 1, so req0 wins the first tie. It updates only on a completed transfer.
  - reqN_ready_out = (state==ARB) && free && grant==N. It is combinational and may depend on both valid inputs.
  - At most one ready is high per cycle. Both are 0 in SWEEP.
  - A transfer loads the register at the same edge with gray(reqN_bin_in) and src=N.
- **Sweep:**
  - The counter resets to 0 on entry.
  - Each cycle the register is free, the block loads gray(cnt) with src=2 and increments cnt.
  - The sweep stalls while the register is held.
- **Simultaneous events:**
  - A requester transfer and sweep_start_in in the same ARB cycle: the transfer completes and SWEEP is entered at the same edge.
  - Pending requests wait, with ready=0, until the sweep ends.
- **Reset values:**
  - Outputs: gray_valid_out=0, gray_out=0, gray_src_out=0, sweep_busy_out=0, sweep_done_out=0, ready outputs=0 until the first post-reset cycle in ARB.
  - Internal state: state=ARB, cnt=0, last_served=1.
- **Reset mid-sweep or mid-hold:** an immediate return to reset values. No further sweep codes are emitted and any held result is discarded.

## Timing
- Request latency: a transfer at edge T gives gray_valid_out=1 after T. Throughput is one result per cycle while gray_ready_in=1.
- Sweep timing with gray_ready_in=1 throughout:
  - A pulse sampled at edge T sets sweep_busy_out=1 after T.
  - Code 0 is loaded at T+1, code k at T+1+k.
  - The last code is loaded at T+2^WIDTH. At that edge sweep_busy_out drops and sweep_done_out is 1 for the following cycle.
- Backpressure: each held cycle (valid & !ready) delays the next load by one cycle. No code is dropped or duplicated.
- Arbitration decisions are made in the same cycle. There is no pipeline bubble between grants to alternating requesters.

## Test plan
- **Reset:** assert rst_in asynchronously mid-cycle → all outputs 0 immediately. After release with req0_valid_in=1 and bin=4'b0101 → req0_ready_out=1, then gray_out=4'b0111, src=0.
- **Tie round-robin:** req0=4'b0011 and req1=4'b1000 both held valid for 4 cycles with ready high → results alternate src 0,1,0,1 with gray 4'b0010, 4'b1100, 4'b0010, 4'b1100.
- **Backpressure:** gray_ready_in=0 for 3 cycles after a req1 load of 4'b1111 → gray_out holds at 4'b1000. Both ready outputs stay 0 until gray_ready_in=1.
- **Sweep:** pulse sweep_start_in with ready high → 16 consecutive results 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, all src=2. sweep_done_out pulses once. Requests are blocked throughout.
- **Sweep stall and reset:** drop gray_ready_in for 2 cycles at code 5 → code 5 is held and 6 follows, with no loss. Assert rst_in at code 9 → the sweep aborts and sweep_done_out never pulses.
- **Simultaneous start and transfer:** req0 transfers bin 4'b0110 in the same cycle as sweep_start_in → gray 4'b0101 (src=0) is output, followed by sweep codes starting at 0000.
